// File: rtl/alu_issue_stage_if.sv
// ALU operation encoding shared by the issue stage and the ALU, plus the
// issue-stage handshake interface. The upstream fields and the ALU-facing
// results travel together in one bundle.
package alu_operations;

    typedef enum logic [3:0] {
        Add                    = 4'd0,
        Subtract               = 4'd1,
        Shift_Left_Logical     = 4'd2,
        Set_Less_Than          = 4'd3,
        Set_Less_Than_Unsigned = 4'd4,
        Xor                    = 4'd5,
        Shift_Right_Logical    = 4'd6,
        Shift_Right_Arithmetic = 4'd7,
        Or                     = 4'd8,
        And                    = 4'd9
    } alu_operation_t;

endpackage

interface alu_issue_if #(
    parameter int XLEN = 32
);
    import alu_operations::*;

    // Upstream (decode) side
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_value;
    logic [XLEN-1:0] in_rs2_value;
    logic [XLEN-1:0] in_immediate;

    // Downstream (ALU) side
    logic            out_valid;
    logic            out_ready;
    alu_operation_t  out_operation;
    logic [XLEN-1:0] out_operand_1;
    logic [XLEN-1:0] out_operand_2;
    logic [4:0]      out_rd;
    logic            out_rd_write;
    logic            out_illegal;

    // The issue stage itself
    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rd, in_pc,
               in_rs1_value, in_rs2_value, in_immediate, out_ready,
        output in_ready, out_valid, out_operation, out_operand_1,
               out_operand_2, out_rd, out_rd_write, out_illegal
    );

    // Whoever drives instructions in and consumes ALU inputs
    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7_5, in_rd, in_pc,
               in_rs1_value, in_rs2_value, in_immediate, out_ready,
        input  in_ready, out_valid, out_operation, out_operand_1,
               out_operand_2, out_rd, out_rd_write, out_illegal
    );

endinterface

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the ALU. Decodes opcode/funct3/funct7[5]
// into an ALU operation, selects the operands and holds the decoded entry in a
// 2-entry main/skid buffer so in_ready depends only on registered state.
module alu_issue_stage
    import alu_operations::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        alu_operation_t  operation;
        logic [XLEN-1:0] operand_1;
        logic [XLEN-1:0] operand_2;
        logic [4:0]      rd;
        logic            rd_write;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // funct3 table shared by OP and OP-IMM; alt selects the funct7[5] variant.
    function automatic alu_operation_t alu_table(input logic [2:0] funct3,
                                                 input logic       alt);
        alu_operation_t op;
        case (funct3)
            3'b000:  op = alt ? Subtract : Add;
            3'b001:  op = Shift_Left_Logical;
            3'b010:  op = Set_Less_Than;
            3'b011:  op = Set_Less_Than_Unsigned;
            3'b100:  op = Xor;
            3'b101:  op = alt ? Shift_Right_Arithmetic : Shift_Right_Logical;
            3'b110:  op = Or;
            3'b111:  op = And;
            default: op = Add;
        endcase
        return op;
    endfunction

    // Full decode of one upstream entry. Illegal encodings collapse to an
    // Add of zeros with write-back suppressed.
    function automatic entry_t decode_entry(input logic [6:0]      opcode,
                                            input logic [2:0]      funct3,
                                            input logic            funct7_5,
                                            input logic [4:0]      rd,
                                            input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] rs1,
                                            input logic [XLEN-1:0] rs2,
                                            input logic [XLEN-1:0] imm);
        entry_t e;
        logic   illegal;
        logic   is_op;
        logic   alt;
        e         = '0;
        e.operation = Add;
        illegal   = 1'b0;
        is_op     = (opcode == OPC_OP);
        // OP-IMM only honours funct7[5] for the right shifts, so ADDI stays Add.
        alt       = funct7_5 && (is_op || (funct3 == 3'b101));
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                e.operation = alu_table(funct3, alt);
                e.operand_1 = rs1;
                e.operand_2 = is_op ? rs2 : imm;
                if (is_op && funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                e.operand_2 = imm;
            end
            OPC_AUIPC: begin
                e.operand_1 = pc;
                e.operand_2 = imm;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            e.operation = Add;
            e.operand_1 = '0;
            e.operand_2 = '0;
        end
        e.rd       = rd;
        e.illegal  = illegal;
        e.rd_write = !illegal && (rd != 5'd0);
        return e;
    endfunction

    state_t state;
    state_t state_next;
    entry_t main_entry;
    entry_t skid_entry;
    entry_t new_entry;
    logic   in_ready_int;
    logic   out_valid_int;
    logic   accept;
    logic   fire;
    logic   load_main_new;
    logic   load_main_skid;
    logic   load_skid;

    assign new_entry = decode_entry(bus.in_opcode, bus.in_funct3, bus.in_funct7_5,
                                    bus.in_rd, bus.in_pc, bus.in_rs1_value,
                                    bus.in_rs2_value, bus.in_immediate);

    assign in_ready_int  = (state != TWO);
    assign out_valid_int = (state != EMPTY);
    assign accept        = bus.in_valid && in_ready_int;
    assign fire          = out_valid_int && bus.out_ready;

    // Next-state and buffer-load decisions; flush overrides any accept or fire.
    always_comb begin
        state_next     = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next    = ONE;
                        load_main_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        load_main_new = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // State and the output-facing main entry; reset clears both so the ALU
    // sees a clean Add of zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_entry <= '0;
        end else begin
            state <= state_next;
            if (load_main_new) begin
                main_entry <= new_entry;
            end else if (load_main_skid) begin
                main_entry <= skid_entry;
            end
        end
    end

    // Skid entry captures the overflow entry while the ALU stalls; it is only
    // read in TWO, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_entry <= new_entry;
        end
    end

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = out_valid_int;
    assign bus.out_operation = main_entry.operation;
    assign bus.out_operand_1 = main_entry.operand_1;
    assign bus.out_operand_2 = main_entry.operand_2;
    assign bus.out_rd        = main_entry.rd;
    assign bus.out_rd_write  = main_entry.rd_write;
    assign bus.out_illegal   = main_entry.illegal;

endmodule
